// File: rtl/bm_mem_resp_if.sv
// Host load and controller read bus for the bitmatrix column memory.
// slave = memory side, master = host/controller side.
interface bm_mem_resp_if #(
  parameter int BM_COL_W      = 128,
  parameter int BM_MEM_ADDR_W = 3,
  parameter int HOST_W        = 32
);
  logic                     host_bm_load_start;
  logic                     host_bm_load_end;
  logic                     host_bm_wr_en;
  logic [BM_MEM_ADDR_W-1:0] host_bm_wr_addr;
  logic [HOST_W-1:0]        host_bm_wr_data;
  logic                     bm_cntl_bm_mem_rd_rq;
  logic [BM_MEM_ADDR_W-1:0] bm_cntl_bm_mem_rd_addr;
  logic [BM_COL_W-1:0]      bm_mem_bm_cntl_rd_data;
  logic                     bm_mem_bm_cntl_rd_data_val;
  logic                     bm_mem_ready;
  logic                     bm_mem_load_busy;
  logic                     bm_mem_rd_err;

  modport slave (
    input  host_bm_load_start, host_bm_load_end, host_bm_wr_en,
           host_bm_wr_addr, host_bm_wr_data,
           bm_cntl_bm_mem_rd_rq, bm_cntl_bm_mem_rd_addr,
    output bm_mem_bm_cntl_rd_data, bm_mem_bm_cntl_rd_data_val,
           bm_mem_ready, bm_mem_load_busy, bm_mem_rd_err
  );

  modport master (
    output host_bm_load_start, host_bm_load_end, host_bm_wr_en,
           host_bm_wr_addr, host_bm_wr_data,
           bm_cntl_bm_mem_rd_rq, bm_cntl_bm_mem_rd_addr,
    input  bm_mem_bm_cntl_rd_data, bm_mem_bm_cntl_rd_data_val,
           bm_mem_ready, bm_mem_load_busy, bm_mem_rd_err
  );
endinterface

// File: rtl/bm_mem_resp.sv
// Bitmatrix column memory: host loads columns in HOST_W segments, the
// controller reads whole columns through a fixed-latency pipeline.
module bm_mem_resp #(
  parameter int BM_COL_W      = 128,
  parameter int BM_MEM_ADDR_W = 3,
  parameter int BM_DEPTH      = 8,
  parameter int HOST_W        = 32,
  parameter int RD_LAT        = 2
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            eng_rstn,
  bm_mem_resp_if.slave    bus
);
  localparam int SEG   = BM_COL_W / HOST_W;
  localparam int SEG_W = (SEG > 1) ? $clog2(SEG) : 1;
  localparam int IDX_W = (BM_DEPTH > 1) ? $clog2(BM_DEPTH) : 1;
  localparam logic [SEG_W-1:0]       SEG_LAST = SEG_W'(SEG - 1);
  localparam logic [BM_MEM_ADDR_W:0] DEPTH_L  = BM_DEPTH[BM_MEM_ADDR_W:0];

  typedef enum logic [1:0] {IDLE, LOAD, READY} state_e;

  state_e                          state_q;
  logic                            ready_q, busy_q;
  logic [SEG_W-1:0]                seg_q;
  logic [BM_COL_W-1:0]             asm_q;
  logic [BM_COL_W-1:0]             col_d;
  logic [BM_COL_W-1:0]             mem [BM_DEPTH];
  logic [RD_LAT:1]                 vld_pipe_q;
  logic [RD_LAT:1][BM_COL_W-1:0]   dat_pipe_q;
  logic                            err_q;

  logic wr_fire, wr_last, wr_commit, rd_acc, ld_evt;

  assign ld_evt    = bus.host_bm_load_start | bus.host_bm_load_end;
  assign wr_fire   = (state_q == LOAD) & bus.host_bm_wr_en;
  assign wr_last   = wr_fire & (seg_q == SEG_LAST);
  assign wr_commit = wr_last & ({1'b0, bus.host_bm_wr_addr} < DEPTH_L);
  assign rd_acc    = bus.bm_cntl_bm_mem_rd_rq & (state_q == READY) &
                     ({1'b0, bus.bm_cntl_bm_mem_rd_addr} < DEPTH_L);

  // Column being assembled, with the segment on the bus already merged in.
  always_comb begin
    col_d = asm_q;
    col_d[seg_q*HOST_W +: HOST_W] = bus.host_bm_wr_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      seg_q   <= '0;
      asm_q   <= '0;
    end else begin
      if (wr_fire) begin
        asm_q <= col_d;
        seg_q <= wr_last ? '0 : seg_q + 1'b1;
      end
      // Load boundaries discard any partial column after the write is taken.
      if (ld_evt) begin
        asm_q <= '0;
        seg_q <= '0;
      end
      case (state_q)
        IDLE: if (bus.host_bm_load_start) begin
          state_q <= LOAD;
          busy_q  <= 1'b1;
        end
        LOAD: if (!bus.host_bm_load_start && bus.host_bm_load_end) begin
          state_q <= READY;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        READY: if (bus.host_bm_load_start) begin
          state_q <= LOAD;
          ready_q <= 1'b0;
          busy_q  <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_commit) mem[bus.host_bm_wr_addr[IDX_W-1:0]] <= col_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_pipe_q <= '0;
      dat_pipe_q <= '0;
      err_q      <= 1'b0;
    end else if (!eng_rstn) begin
      vld_pipe_q <= '0;
      err_q      <= 1'b0;
    end else begin
      vld_pipe_q[1] <= rd_acc;
      if (rd_acc) dat_pipe_q[1] <= mem[bus.bm_cntl_bm_mem_rd_addr[IDX_W-1:0]];
      // Stages load only behind a valid, so the last stage holds its value.
      for (int k = 2; k <= RD_LAT; k++) begin
        vld_pipe_q[k] <= vld_pipe_q[k-1];
        if (vld_pipe_q[k-1]) dat_pipe_q[k] <= dat_pipe_q[k-1];
      end
      err_q <= bus.bm_cntl_bm_mem_rd_rq & ~rd_acc;
    end
  end

  assign bus.bm_mem_bm_cntl_rd_data     = dat_pipe_q[RD_LAT];
  assign bus.bm_mem_bm_cntl_rd_data_val = vld_pipe_q[RD_LAT];
  assign bus.bm_mem_rd_err              = err_q;
  assign bus.bm_mem_ready               = ready_q;
  assign bus.bm_mem_load_busy           = busy_q;
endmodule

// File: tb/tb_bm_mem_resp.sv
// Scoreboard bench: stimulus pushes expected read/error events from a
// queue-based reference model; a negedge monitor pops and compares them.
module tb_bm_mem_resp;
  localparam int COL = 128, AW = 4, DEP = 8, HW = 32, LAT = 2;

  typedef struct {
    int               due;
    logic [COL-1:0]   data;
  } exp_t;

  logic clk = 1'b0, rstn = 1'b0, eng_rstn = 1'b1;
  always #5 clk = ~clk;

  bm_mem_resp_if #(.BM_COL_W(COL), .BM_MEM_ADDR_W(AW), .HOST_W(HW)) bus ();

  bm_mem_resp #(.BM_COL_W(COL), .BM_MEM_ADDR_W(AW), .BM_DEPTH(DEP),
                .HOST_W(HW), .RD_LAT(LAT)) dut (
    .clk(clk), .rstn(rstn), .eng_rstn(eng_rstn), .bus(bus)
  );

  int n_vec = 0, n_err = 0, cyc = 0;
  exp_t exp_q[$];
  int   err_exp_q[$];
  logic [COL-1:0] ref_mem [16];
  logic [HW-1:0]  segs[$];
  int             mode = 0;       // 0 idle, 1 load, 2 ready
  logic [COL-1:0] last_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [COL-1:0] got, input logic [COL-1:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  // One clock of stimulus; the model consumes pre-edge state exactly once.
  task automatic step(input logic ls, le, we, input logic [AW-1:0] wa,
                      input logic [HW-1:0] wd, input logic rq,
                      input logic [AW-1:0] ra, input logic eng);
    @(posedge clk); #1;
    chk("ready", COL'(bus.bm_mem_ready), COL'(mode == 2));
    chk("load_busy", COL'(bus.bm_mem_load_busy), COL'(mode == 1));
    bus.host_bm_load_start = ls; bus.host_bm_load_end = le;
    bus.host_bm_wr_en = we; bus.host_bm_wr_addr = wa; bus.host_bm_wr_data = wd;
    bus.bm_cntl_bm_mem_rd_rq = rq; bus.bm_cntl_bm_mem_rd_addr = ra;
    eng_rstn = eng;
    if (!eng) begin
      while (exp_q.size() > 0 && exp_q[$].due >= cyc + 1) void'(exp_q.pop_back());
    end else if (rq) begin
      if (mode == 2 && ra < DEP) exp_q.push_back('{cyc + LAT, ref_mem[ra]});
      else err_exp_q.push_back(cyc + 1);
    end
    if (mode == 1 && we) begin
      segs.push_back(wd);
      if (segs.size() == COL / HW) begin
        if (wa < DEP) ref_mem[wa] = {segs[3], segs[2], segs[1], segs[0]};
        segs.delete();
      end
    end
    if (ls || le) segs.delete();
    if (ls) mode = 1;
    else if (le && mode == 1) mode = 2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, '0, 0, '0, 1);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    step(0, 0, 0, '0, '0, 1, a, 1);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [HW-1:0] d);
    step(0, 0, 1, a, d, 0, '0, 1);
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      if (bus.bm_mem_bm_cntl_rd_data_val) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_val", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("val_cycle", COL'(cyc), COL'(e.due));
          chk("rd_data", bus.bm_mem_bm_cntl_rd_data, e.data);
          last_data = e.data;
        end
      end else begin
        chk("rd_data_hold", bus.bm_mem_bm_cntl_rd_data, last_data);
        if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
          chk("missing_val", 0, 1);
          void'(exp_q.pop_front());
        end
      end
      if (bus.bm_mem_rd_err) begin
        if (err_exp_q.size() == 0) chk("unexpected_err", 1, 0);
        else chk("err_cycle", COL'(cyc), COL'(err_exp_q.pop_front()));
      end else if (err_exp_q.size() > 0 && err_exp_q[0] <= cyc) begin
        chk("missing_err", 0, 1);
        void'(err_exp_q.pop_front());
      end
    end
  end

  initial begin
    bus.host_bm_load_start = 0; bus.host_bm_load_end = 0; bus.host_bm_wr_en = 0;
    bus.host_bm_wr_addr = '0; bus.host_bm_wr_data = '0;
    bus.bm_cntl_bm_mem_rd_rq = 0; bus.bm_cntl_bm_mem_rd_addr = '0;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", COL'(bus.bm_mem_ready), 0);
    chk("rst_busy", COL'(bus.bm_mem_load_busy), 0);
    chk("rst_val", COL'(bus.bm_mem_bm_cntl_rd_data_val), 0);
    chk("rst_err", COL'(bus.bm_mem_rd_err), 0);
    chk("rst_data", bus.bm_mem_bm_cntl_rd_data, '0);
    rstn = 1'b1;

    rd(1); idle(2);                                   // read in IDLE -> err
    step(1, 0, 0, '0, '0, 0, '0, 1);
    for (int a = 0; a < DEP; a++)
      for (int s = 0; s < 4; s++)
        wr(AW'(a), (a == 2) ? HW'((s + 1) * 32'h11111111) : $urandom);
    for (int s = 0; s < 4; s++) wr(4'd9, $urandom);   // out-of-range commit dropped
    step(0, 1, 0, '0, '0, 0, '0, 1);
    rd(2); idle(3);
    rd(0); rd(1); rd(2); idle(3);
    rd(9); idle(2);
    rd(5); step(0, 0, 0, '0, '0, 0, '0, 0); idle(2); rd(5); idle(3);
    step(1, 0, 0, '0, '0, 1, 4'd3, 1);                // read + load_start together
    wr(4, 32'hAAAA0000); wr(4, 32'hAAAA0001);
    step(0, 1, 0, '0, '0, 0, '0, 1);                  // partial column discarded
    step(1, 0, 0, '0, '0, 0, '0, 1);
    wr(4, 32'hB0B00000); wr(4, 32'hB0B00001); wr(4, 32'hB0B00002);
    step(0, 1, 1, 4'd4, 32'hB0B00003, 0, '0, 1);      // final segment with load_end
    rd(4); rd(3); idle(3);

    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 39) == 0, $urandom_range(0, 11) == 0, 1'($urandom),
           AW'($urandom_range(0, 9)), $urandom, 1'($urandom),
           AW'($urandom_range(0, 9)), $urandom_range(0, 29) != 0);
    idle(6);
    chk("drain_val", COL'(exp_q.size()), 0);
    chk("drain_err", COL'(err_exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/bm_mem_resp.md
BM_MEM_RESP -- requirements
Module: bm_mem_resp

Interface
REQ-001 SHALL have parameter BM_COL_W, default 128, bitmatrix column width in bits.
REQ-002 SHALL have parameter BM_MEM_ADDR_W, default 3, column address width.
REQ-003 SHALL have parameter BM_DEPTH, default 8, number of stored columns (≤ 2^BM_MEM_ADDR_W).
REQ-004 SHALL have parameter HOST_W, default 32, host write segment width; BM_COL_W divisible by HOST_W; SEG = BM_COL_W/HOST_W.
REQ-005 SHALL have parameter RD_LAT, default 2, read latency in cycles, legal range 1..4.
REQ-006 SHALL have port clk input 1: clock.
REQ-007 SHALL have port rstn input 1: reset, asynchronous, active-low.
REQ-008 SHALL have port eng_rstn input 1: synchronous active-low engine reset; clears the read pipeline only.
REQ-009 SHALL have port host_bm_load_start input 1: pulse, begin loading.
REQ-010 SHALL have port host_bm_load_end input 1: pulse, finish loading.
REQ-011 SHALL have port host_bm_wr_en input 1: segment write strobe.
REQ-012 SHALL have port host_bm_wr_addr input BM_MEM_ADDR_W: target column.
REQ-013 SHALL have port host_bm_wr_data input HOST_W: segment data.
REQ-014 SHALL have port bm_cntl_bm_mem_rd_rq input 1: read request.
REQ-015 SHALL have port bm_cntl_bm_mem_rd_addr input BM_MEM_ADDR_W: read column address.
REQ-016 SHALL have port bm_mem_bm_cntl_rd_data output BM_COL_W: read column data.
REQ-017 SHALL have port bm_mem_bm_cntl_rd_data_val output 1: read data valid, one-cycle pulse per accepted request.
REQ-018 SHALL have port bm_mem_ready output 1: high in READY state.
REQ-019 SHALL have port bm_mem_load_busy output 1: high in LOAD state.
REQ-020 SHALL have port bm_mem_rd_err output 1: one-cycle pulse on rejected request.

Function
REQ-021 SHALL implement FSM states IDLE, LOAD, READY; IDLE->LOAD on load_start; LOAD->READY on load_end; READY->LOAD on load_start; load_start and load_end in the same cycle: load_start wins.
REQ-022 SHALL, in LOAD, on wr_en, place wr_data at bits [seg*HOST_W +: HOST_W] of an assembly register; seg counter 0..SEG-1, wraps to 0.
REQ-023 SHALL commit the assembly register, with the current segment merged in, to mem[wr_addr] in the cycle the segment at seg=SEG-1 is written; wr_addr sampled on that final segment only.
REQ-024 SHALL ignore wr_en outside LOAD, and ignore commits with wr_addr ≥ BM_DEPTH; the seg counter still advances and wraps.
REQ-025 SHALL clear the seg counter and discard any partial column on load_end or load_start; a wr_en coinciding with load_end is processed first, so a completing segment commits.
REQ-026 SHALL accept rd_rq only in READY with rd_addr < BM_DEPTH; accepted request -> rd_data = mem[rd_addr], rd_data_val=1 exactly RD_LAT cycles later.
REQ-027 SHALL sample memory at request cycle; a simultaneous commit to the same address returns old data.
REQ-028 SHALL accept one request per cycle, fully pipelined, no backpressure.
REQ-029 SHALL reject rd_rq outside READY or with rd_addr ≥ BM_DEPTH: rd_err pulses 1 cycle later; no rd_data_val is produced for it.
REQ-030 SHALL complete requests already in the pipeline on a READY->LOAD transition.
REQ-031 SHALL hold rd_data at its last value when rd_data_val=0.
REQ-032 SHALL, on eng_rstn=0, drop all in-flight reads, drive rd_data_val=0 and rd_err=0, and leave memory contents, FSM, and load state unchanged.

Reset
REQ-033 SHALL, on rstn low: FSM=IDLE, seg counter=0, assembly reg=0, pipeline empty, rd_data=0, rd_data_val=0, rd_err=0, ready=0, load_busy=0.
REQ-034 SHALL NOT clear memory contents on reset; reads are impossible until READY.

Verification
REQ-035 Load: start; 4 writes 0x11111111..0x44444444 to addr 2; end; rd addr 2 -> rd_data_val at T+2, data=0x44444444_33333333_22222222_11111111.
REQ-036 Back-to-back reads of addr 0,1,2 on consecutive cycles -> val on 3 consecutive cycles, in order.
REQ-037 rd_rq in IDLE, and rd_addr=9 with BM_DEPTH=8 -> rd_err pulse at T+1, no val.
REQ-038 2 segments, then load_end -> seg reset; next load of 4 segments commits a correct column without residue.
REQ-039 Read issued at T, eng_rstn low at T+1 -> no val; memory intact on re-read.
REQ-040 READY, read addr 3 at T with load_start at T -> val at T+2 with old data; ready=0 from T+1.
